vc_input_port: RTL and testbench
================================

# vc_input_port

Parametrised router input port with per-VC circular buffers, per-VC packet state machines, route computation on the head flit at each buffer front, and selectable on/off or credit-based upstream flow control. It sits between the upstream link and the router's VC allocator, switch allocator and crossbar. Downstream-VC rewriting and error flagging are built in.

## Interface
- BUFFER_SIZE, 8, flits per VC buffer (≥2, any integer)
- PIPELINE_DEPTH, 5, on/off threshold margin (< BUFFER_SIZE)
- FLOW_CTRL, 0, 0 = on/off, 1 = credit
- X_CURRENT, MESH_SIZE_X/2, router x coordinate
- Y_CURRENT, MESH_SIZE_Y/2, router y coordinate

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- data_i  in  flit_t  incoming flit
- valid_flit_i  in  1  data_i valid
- va_vc_new_i  in  VC_NUM×VC_SIZE  downstream VC granted, per VC
- va_vc_valid_i  in  VC_NUM  VA grant strobe, per VC
- sa_valid_sel_i  in  1  switch grant valid
- sa_vc_sel_i  in  VC_SIZE  VC granted by SA
- flit_o  out  flit_t  granted flit, vc_id replaced by downstream VC
- out_port_o  out  VC_NUM×port_t  registered route per VC
- va_request_o  out  VC_NUM  VC in VA state
- sa_request_o  out  VC_NUM  VC ACTIVE and non-empty
- on_off_o  out  VC_NUM  on/off signal to upstream
- credit_o  out  1  one-flit credit return
- credit_vc_o  out  VC_SIZE  VC of returned credit
- vc_allocatable_o  out  VC_NUM  VC IDLE and empty
- error_o  out  1  sticky protocol error

## Operation
- Write: valid_flit_i stores data_i into buffer data_i.vc_id. Write to a full VC drops the flit and sets error_o. Write and read of the same full VC in the same cycle are both accepted; occupancy is unchanged.
- Read: sa_valid_sel_i pops the front of buffer sa_vc_sel_i. flit_o = front flit with vc_id := stored downstream VC, combinational in the same cycle. A read of an empty or non-ACTIVE VC is ignored, sets error_o, and flit_o is don't-care.
- Per-VC FSM:
  - IDLE → VA when buffer non-empty and the front flit is HEAD or HEADTAIL; out_port_o[v] is registered from rc_unit applied to the front flit.
  - VA → ACTIVE on va_vc_valid_i[v]; va_vc_new_i[v] is latched.
  - ACTIVE → IDLE on a read of a TAIL or HEADTAIL flit.
  - A non-head flit at the front in IDLE is a protocol error: set error_o, stay IDLE.
- Flow control, FLOW_CTRL=0: on_off_o[v] = 1 while free slots > PIPELINE_DEPTH; credit_o = 0.
- Flow control, FLOW_CTRL=1: credit_o pulses once per accepted read, with credit_vc_o = VC read; on_off_o = all ones.
- Occupancy counter width is $clog2(BUFFER_SIZE+1). Read and write pointers wrap BUFFER_SIZE-1 → 0.

## Timing
- Reset values: all buffers empty, all FSMs IDLE.
  - out_port_o = LOCAL; va_request_o = 0; sa_request_o = 0.
  - on_off_o = all ones; credit_o = 0; credit_vc_o = 0.
  - vc_allocatable_o = all ones; error_o = 0.
- Write at edge t: flit visible at the front at t+1.
- Head at front at t+1: VA state and va_request_o at t+2.
- va_vc_valid_i at cycle c: ACTIVE and sa_request_o at c+1.
- Read in cycle r: flit_o valid in r; pointer and occupancy update at edge r→r+1.
- Credit: credit_o is registered, high in r+1 for one cycle.
- on_off_o is registered from the post-update occupancy.
- After a tail read, the next packet's head reaches VA no earlier than 2 cycles later (IDLE, then VA).
- rst asserted mid-packet: immediate clear; buffered flits are discarded.

## Structure
- noc_params package holds flit_t, flit_label_t, port_t, VC_NUM, VC_SIZE, mesh sizes, and a new vc_state_t (IDLE, VA, ACTIVE).
- Sub-module vc_fifo: one circular buffer plus occupancy counter, instantiated VC_NUM times.
- Existing rc_unit is instantiated once per VC on each front flit.
- FSM and flow-control logic live in the top module.

## Test plan
- HEADTAIL to VC0, dest = current router, VA grants VC2, SA selects VC0 → flit_o.vc_id=2, out_port_o[0]=LOCAL, VC0 back to IDLE, vc_allocatable_o[0]=1 two cycles after read.
- FLOW_CTRL=0, BUFFER_SIZE=8, PIPELINE_DEPTH=5: write 3 flits to VC1 → on_off_o[1] drops after the third write; one read → it rises again.
- FLOW_CTRL=1: read 4 flits of a packet from VC1 → four credit_o pulses with credit_vc_o=1, each one cycle after its read.
- Write 9 flits to a VC with no reads → 9th dropped, error_o=1 sticky, occupancy 8; then write+read together → both accepted, occupancy stays 8.
- Two packets back-to-back in VC0 → second head enters VA only after the first tail read; route is recomputed for the new destination.
- Assert rst with VC0 ACTIVE holding 3 flits → all outputs at reset values immediately, no credit pulse.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC types and sizes: flit format, output ports, per-VC packet states.
package noc_params;

  localparam int MESH_SIZE_X      = 4;
  localparam int MESH_SIZE_Y      = 4;
  localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
  localparam int VC_NUM           = 4;
  localparam int VC_SIZE          = $clog2(VC_NUM);
  localparam int FLIT_DATA_SIZE   = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
  typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

  typedef struct packed {
    flit_label_t                 flit_label;
    logic [VC_SIZE-1:0]          vc_id;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [FLIT_DATA_SIZE-1:0]   data;
  } flit_t;

  function automatic logic is_head(flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic is_tail(flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction

endpackage

// File: rtl/rc_unit.sv
// XY dimension-order route computation: resolve X first, then Y, else eject.
module rc_unit import noc_params::*; #(
  parameter int X_CURRENT = MESH_SIZE_X/2,
  parameter int Y_CURRENT = MESH_SIZE_Y/2
)(
  input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i,
  output port_t                       out_port_o
);

  localparam logic [DEST_ADDR_SIZE_X-1:0] XC = DEST_ADDR_SIZE_X'(X_CURRENT);
  localparam logic [DEST_ADDR_SIZE_Y-1:0] YC = DEST_ADDR_SIZE_Y'(Y_CURRENT);

  // Pick the output port; y grows towards SOUTH.
  always_comb begin
    if (x_dest_i > XC)      out_port_o = EAST;
    else if (x_dest_i < XC) out_port_o = WEST;
    else if (y_dest_i > YC) out_port_o = SOUTH;
    else if (y_dest_i < YC) out_port_o = NORTH;
    else                    out_port_o = LOCAL;
  end

endmodule

// File: rtl/vc_fifo.sv
// One VC circular buffer with occupancy counter. Caller guarantees wr_i only
// when not full (or reading in the same cycle) and rd_i only when not empty.
module vc_fifo import noc_params::*; #(
  parameter int BUFFER_SIZE = 8
)(
  input  logic                               clk,
  input  logic                               rst,
  input  flit_t                              data_i,
  input  logic                               wr_i,
  input  logic                               rd_i,
  output flit_t                              data_o,
  output logic                               empty_o,
  output logic                               full_o,
  output logic [$clog2(BUFFER_SIZE+1)-1:0]   count_nxt_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = $clog2(BUFFER_SIZE+1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(BUFFER_SIZE-1);

  flit_t             mem_q [BUFFER_SIZE];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Pointer wrap and occupancy update; simultaneous wr+rd leaves count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_i) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rd_i) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    if (wr_i && !rd_i)      cnt_d = cnt_q + 1'b1;
    else if (!wr_i && rd_i) cnt_d = cnt_q - 1'b1;
  end

  // Control state; reset empties the buffer without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Flit storage.
  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o      = mem_q[rd_ptr_q];
  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == CNT_W'(BUFFER_SIZE));
  assign count_nxt_o = cnt_d;

endmodule

// File: rtl/vc_input_port.sv
// Router input port: per-VC buffers, packet FSMs, route computation and
// upstream flow control (on/off or credit, chosen by FLOW_CTRL).
module vc_input_port import noc_params::*; #(
  parameter int BUFFER_SIZE    = 8,
  parameter int PIPELINE_DEPTH = 5,
  parameter int FLOW_CTRL      = 0,
  parameter int X_CURRENT      = MESH_SIZE_X/2,
  parameter int Y_CURRENT      = MESH_SIZE_Y/2
)(
  input  logic                             clk,
  input  logic                             rst,
  input  flit_t                            data_i,
  input  logic                             valid_flit_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]   va_vc_new_i,
  input  logic [VC_NUM-1:0]                va_vc_valid_i,
  input  logic                             sa_valid_sel_i,
  input  logic [VC_SIZE-1:0]               sa_vc_sel_i,
  output flit_t                            flit_o,
  output port_t [VC_NUM-1:0]               out_port_o,
  output logic [VC_NUM-1:0]                va_request_o,
  output logic [VC_NUM-1:0]                sa_request_o,
  output logic [VC_NUM-1:0]                on_off_o,
  output logic                             credit_o,
  output logic [VC_SIZE-1:0]               credit_vc_o,
  output logic [VC_NUM-1:0]                vc_allocatable_o,
  output logic                             error_o
);

  localparam int CNT_W = $clog2(BUFFER_SIZE+1);
  localparam logic [CNT_W-1:0] ON_LIMIT = CNT_W'(BUFFER_SIZE - PIPELINE_DEPTH);

  flit_t     [VC_NUM-1:0]             front;
  port_t     [VC_NUM-1:0]             route, out_port_q, out_port_d;
  vc_state_t [VC_NUM-1:0]             state_q, state_d;
  logic      [VC_NUM-1:0][VC_SIZE-1:0] dvc_q, dvc_d;
  logic      [VC_NUM-1:0][CNT_W-1:0]  cnt_nxt;
  logic      [VC_NUM-1:0]             empty, full, wr_req, wr_en, rd_en, head_err;
  logic      [VC_NUM-1:0]             on_off_q;
  logic                               rd_ok, err_q, credit_q;
  logic      [VC_SIZE-1:0]            credit_vc_q;

  // A read is honoured only for an ACTIVE, non-empty VC.
  assign rd_ok = sa_valid_sel_i && (state_q[sa_vc_sel_i] == ACTIVE) && !empty[sa_vc_sel_i];

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign wr_req[v] = valid_flit_i && (data_i.vc_id == VC_SIZE'(v));
    assign rd_en[v]  = rd_ok && (sa_vc_sel_i == VC_SIZE'(v));
    // A full VC still takes a write when it is being read the same cycle.
    assign wr_en[v]  = wr_req[v] && (!full[v] || rd_en[v]);

    vc_fifo #(.BUFFER_SIZE(BUFFER_SIZE)) u_fifo (
      .clk(clk), .rst(rst), .data_i(data_i), .wr_i(wr_en[v]), .rd_i(rd_en[v]),
      .data_o(front[v]), .empty_o(empty[v]), .full_o(full[v]), .count_nxt_o(cnt_nxt[v])
    );

    rc_unit #(.X_CURRENT(X_CURRENT), .Y_CURRENT(Y_CURRENT)) u_rc (
      .x_dest_i(front[v].x_dest), .y_dest_i(front[v].y_dest), .out_port_o(route[v])
    );
  end

  // Packet state, route and downstream VC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= {VC_NUM{IDLE}};
      out_port_q <= {VC_NUM{LOCAL}};
      dvc_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_port_q <= out_port_d;
      dvc_q      <= dvc_d;
    end
  end

  // Per-VC next state; a non-head flit at an IDLE front is a protocol error.
  always_comb begin
    state_d    = state_q;
    out_port_d = out_port_q;
    dvc_d      = dvc_q;
    head_err   = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      case (state_q[v])
        IDLE: if (!empty[v]) begin
          if (is_head(front[v].flit_label)) begin
            state_d[v]    = VA;
            out_port_d[v] = route[v];
          end else begin
            head_err[v] = 1'b1;
          end
        end
        VA: if (va_vc_valid_i[v]) begin
          state_d[v] = ACTIVE;
          dvc_d[v]   = va_vc_new_i[v];
        end
        ACTIVE: if (rd_en[v] && is_tail(front[v].flit_label)) state_d[v] = IDLE;
        default: state_d[v] = IDLE;
      endcase
    end
  end

  // Allocator-facing requests decoded from state and occupancy.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      va_request_o[v]     = (state_q[v] == VA);
      sa_request_o[v]     = (state_q[v] == ACTIVE) && !empty[v];
      vc_allocatable_o[v] = (state_q[v] == IDLE) && empty[v];
    end
  end

  // Granted flit leaves with its downstream VC id.
  always_comb begin
    flit_o       = front[sa_vc_sel_i];
    flit_o.vc_id = dvc_q[sa_vc_sel_i];
  end

  // Sticky error plus flow-control registers (on/off from post-update count).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= 1'b0;
      on_off_q    <= '1;
      credit_q    <= 1'b0;
      credit_vc_q <= '0;
    end else begin
      err_q    <= err_q || (sa_valid_sel_i && !rd_ok) || |(wr_req & ~wr_en) || |head_err;
      for (int v = 0; v < VC_NUM; v++) on_off_q[v] <= (cnt_nxt[v] < ON_LIMIT);
      credit_q <= rd_ok;
      if (rd_ok) credit_vc_q <= sa_vc_sel_i;
    end
  end

  assign out_port_o  = out_port_q;
  assign error_o     = err_q;
  assign on_off_o    = (FLOW_CTRL == 1) ? '1 : on_off_q;
  assign credit_o    = (FLOW_CTRL == 1) && credit_q;
  assign credit_vc_o = (FLOW_CTRL == 1) ? credit_vc_q : '0;

endmodule

// File: tb/tb_vc_input_port.sv
// Bench for vc_input_port: on/off and credit instances share stimulus and are
// compared every cycle against a queue-based packet model.
module tb_vc_input_port;
  import noc_params::*;

  localparam int BS = 8;
  localparam int PD = 5;

  logic clk = 1'b0;
  logic rst;
  flit_t data_i;
  logic valid_flit_i;
  logic [3:0][1:0] va_vc_new_i;
  logic [3:0] va_vc_valid_i;
  logic sa_valid_sel_i;
  logic [1:0] sa_vc_sel_i;

  flit_t fo0, fo1;
  port_t [3:0] op0, op1;
  logic [3:0] vr0, vr1, sr0, sr1, oo0, oo1, va0, va1;
  logic cr0, cr1, er0, er1;
  logic [1:0] cv0, cv1;

  int vecs = 0;
  int fails = 0;
  int ncred = 0;

  always #5 clk = ~clk;

  vc_input_port #(.BUFFER_SIZE(BS), .PIPELINE_DEPTH(PD), .FLOW_CTRL(0)) u_onoff (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i),
    .va_vc_new_i(va_vc_new_i), .va_vc_valid_i(va_vc_valid_i),
    .sa_valid_sel_i(sa_valid_sel_i), .sa_vc_sel_i(sa_vc_sel_i),
    .flit_o(fo0), .out_port_o(op0), .va_request_o(vr0), .sa_request_o(sr0),
    .on_off_o(oo0), .credit_o(cr0), .credit_vc_o(cv0),
    .vc_allocatable_o(va0), .error_o(er0));

  vc_input_port #(.BUFFER_SIZE(BS), .PIPELINE_DEPTH(PD), .FLOW_CTRL(1)) u_cred (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i),
    .va_vc_new_i(va_vc_new_i), .va_vc_valid_i(va_vc_valid_i),
    .sa_valid_sel_i(sa_valid_sel_i), .sa_vc_sel_i(sa_vc_sel_i),
    .flit_o(fo1), .out_port_o(op1), .va_request_o(vr1), .sa_request_o(sr1),
    .on_off_o(oo1), .credit_o(cr1), .credit_vc_o(cv1),
    .vc_allocatable_o(va1), .error_o(er1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each VC: a queue of flits plus a packet phase (0 waiting for head,
  // 1 awaiting VC grant, 2 streaming), the route of the current packet and
  // the granted downstream VC.
  flit_t      mq[4][$];
  int         mph[4];
  port_t      mroute[4];
  logic [1:0] mdvc[4];
  logic [3:0] moo;
  logic       mcr;
  logic [1:0] mcv;
  logic       merr;
  bit         m_rd;
  int         m_s, m_d;

  function automatic bit lbl_head(flit_t f);
    return f.flit_label == HEAD || f.flit_label == HEADTAIL;
  endfunction
  function automatic bit lbl_tail(flit_t f);
    return f.flit_label == TAIL || f.flit_label == HEADTAIL;
  endfunction
  // Router sits at (2,2); X resolved before Y, larger y is south.
  function automatic port_t route_of(flit_t f);
    if (int'(f.x_dest) > 2) return EAST;
    if (int'(f.x_dest) < 2) return WEST;
    if (int'(f.y_dest) > 2) return SOUTH;
    if (int'(f.y_dest) < 2) return NORTH;
    return LOCAL;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < 4; v++) begin
        mq[v].delete(); mph[v] = 0; mroute[v] = LOCAL; mdvc[v] = 2'd0;
      end
      moo = 4'hF; mcr = 1'b0; mcv = 2'd0; merr = 1'b0;
    end else begin
      m_s  = int'(sa_vc_sel_i);
      m_rd = sa_valid_sel_i && mph[m_s] == 2 && mq[m_s].size() > 0;
      if (sa_valid_sel_i && !m_rd) merr = 1'b1;
      for (int v = 0; v < 4; v++) begin
        if (mph[v] == 0 && mq[v].size() > 0) begin
          if (lbl_head(mq[v][0])) begin mph[v] = 1; mroute[v] = route_of(mq[v][0]); end
          else merr = 1'b1;
        end else if (mph[v] == 1 && va_vc_valid_i[v]) begin
          mph[v] = 2; mdvc[v] = va_vc_new_i[v];
        end else if (mph[v] == 2 && m_rd && m_s == v && lbl_tail(mq[v][0])) begin
          mph[v] = 0;
        end
      end
      if (m_rd) void'(mq[m_s].pop_front());
      if (valid_flit_i) begin
        m_d = int'(data_i.vc_id);
        if (mq[m_d].size() < BS) mq[m_d].push_back(data_i);
        else merr = 1'b1;
      end
      for (int v = 0; v < 4; v++) moo[v] = (BS - mq[v].size()) > PD;
      mcr = m_rd;
      if (m_rd) mcv = sa_vc_sel_i;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [3:0]  e_vr, e_sr, e_va;
  logic [11:0] e_op;
  flit_t       e_fo;
  bit          e_rd;
  int          e_s;

  always @(negedge clk) begin
    for (int v = 0; v < 4; v++) begin
      e_vr[v] = mph[v] == 1;
      e_sr[v] = mph[v] == 2 && mq[v].size() > 0;
      e_va[v] = mph[v] == 0 && mq[v].size() == 0;
      e_op[v*3 +: 3] = mroute[v];
    end
    e_s  = int'(sa_vc_sel_i);
    e_rd = !rst && sa_valid_sel_i && mph[e_s] == 2 && mq[e_s].size() > 0;
    chk("va_request onoff", vr0, e_vr);   chk("va_request credit", vr1, e_vr);
    chk("sa_request onoff", sr0, e_sr);   chk("sa_request credit", sr1, e_sr);
    chk("allocatable onoff", va0, e_va);  chk("allocatable credit", va1, e_va);
    chk("out_port onoff", op0, e_op);     chk("out_port credit", op1, e_op);
    chk("error onoff", er0, merr);        chk("error credit", er1, merr);
    chk("on_off onoff", oo0, moo);        chk("credit onoff", cr0, 1'b0);
    chk("on_off credit", oo1, 4'hF);      chk("credit credit", cr1, mcr);
    if (mcr) chk("credit_vc", cv1, mcv);
    if (e_rd) begin
      e_fo = mq[e_s][0];
      e_fo.vc_id = mdvc[e_s];
      chk("flit_o onoff", fo0, e_fo);
      chk("flit_o credit", fo1, e_fo);
    end
    if (cr1 && cv1 == 2'd1) ncred++;
  end

  // ---------------- stimulus ----------------
  function automatic flit_t mkf(flit_label_t l, int vc, int x, int y, int d);
    flit_t f;
    f.flit_label = l; f.vc_id = 2'(vc); f.x_dest = 2'(x); f.y_dest = 2'(y); f.data = 16'(d);
    return f;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
    valid_flit_i = 1'b0; va_vc_valid_i = '0; sa_valid_sel_i = 1'b0;
  endtask
  task automatic wr(flit_label_t l, int vc, int x, int y, int d);
    data_i = mkf(l, vc, x, y, d); valid_flit_i = 1'b1;
  endtask
  task automatic grant(int vc, int nv);
    va_vc_valid_i[vc] = 1'b1; va_vc_new_i[vc] = 2'(nv);
  endtask
  task automatic rdv(int vc);
    sa_valid_sel_i = 1'b1; sa_vc_sel_i = 2'(vc);
  endtask

  initial begin
    rst = 1'b1; data_i = '0; valid_flit_i = 1'b0; va_vc_new_i = '0;
    va_vc_valid_i = '0; sa_valid_sel_i = 1'b0; sa_vc_sel_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_port", op0, 12'h0);   chk("reset on_off", oo0, 4'hF);
    chk("reset allocatable", va0, 4'hF); chk("reset error", er0, 1'b0);
    chk("reset credit", cr1, 1'b0);      chk("reset credit_vc", cv0, 2'd0);
    rst = 1'b0;
    cyc();

    // Single HEADTAIL to the local port, re-labelled to downstream VC2.
    wr(HEADTAIL, 0, 2, 2, 16'hA1); cyc();
    cyc();
    chk("t1 va_request", vr0[0], 1'b1);
    grant(0, 2); cyc();
    rdv(0); #1;
    chk("t1 flit vc_id", fo0.vc_id, 2'd2);
    chk("t1 flit data", fo0.data, 16'hA1);
    chk("t1 out_port", op0[0], LOCAL);
    cyc(); cyc();
    chk("t1 allocatable", va0[0], 1'b1);

    // On/off threshold on VC1, then a 4-flit packet drained for credits.
    ncred = 0;
    wr(HEAD, 1, 3, 2, 1); cyc();
    wr(BODY, 1, 3, 2, 2); cyc();
    chk("t2 on_off 2 flits", oo0[1], 1'b1);
    wr(BODY, 1, 3, 2, 3); cyc();
    chk("t2 on_off 3 flits", oo0[1], 1'b0);
    grant(1, 1); cyc();
    rdv(1); cyc();
    chk("t2 on_off after read", oo0[1], 1'b1);
    chk("t2 route east", op0[1], EAST);
    wr(TAIL, 1, 3, 2, 4); cyc();
    for (int i = 0; i < 3; i++) begin rdv(1); cyc(); end
    cyc();
    chk("t3 credit pulses", ncred, 4);

    // Overfill VC3: ninth flit dropped, then simultaneous write+read when full.
    for (int i = 0; i < 9; i++) begin wr(i == 0 ? HEAD : BODY, 3, 1, 2, 16'h30 + i); cyc(); end
    chk("t4 error onoff", er0, 1'b1);
    chk("t4 error credit", er1, 1'b1);
    chk("t4 model occupancy", mq[3].size(), 8);
    grant(3, 0); cyc();
    wr(TAIL, 3, 1, 2, 16'h3F); rdv(3); cyc();
    chk("t4 occupancy after wr+rd", mq[3].size(), 8);
    chk("t4 sa_request full", sr0[3], 1'b1);
    for (int i = 0; i < 8; i++) begin rdv(3); cyc(); end
    cyc();
    chk("t4 drained allocatable", va0[3], 1'b1);
    chk("t4 error sticky", er0, 1'b1);

    // Back-to-back packets in VC0 with different routes.
    wr(HEAD, 0, 3, 2, 16'h50); cyc();
    wr(BODY, 0, 3, 2, 16'h51); cyc();
    wr(TAIL, 0, 3, 2, 16'h52); cyc();
    wr(HEAD, 0, 0, 2, 16'h60); cyc();
    wr(TAIL, 0, 0, 2, 16'h61); cyc();
    chk("t5 first route", op0[0], EAST);
    grant(0, 1); cyc();
    for (int i = 0; i < 3; i++) begin rdv(0); cyc(); end
    chk("t5 idle after tail", vr0[0], 1'b0);
    cyc();
    chk("t5 second head in VA", vr0[0], 1'b1);
    chk("t5 second route", op0[0], WEST);
    grant(0, 3); cyc();
    rdv(0); #1;
    chk("t5 second vc_id", fo0.vc_id, 2'd3);
    cyc();
    rdv(0); cyc(); cyc();

    // Reset while VC0 is ACTIVE with three flits and a read pending.
    wr(HEAD, 0, 2, 3, 16'h70); cyc();
    wr(BODY, 0, 2, 3, 16'h71); cyc();
    wr(BODY, 0, 2, 3, 16'h72); cyc();
    grant(0, 2); cyc();
    chk("t6 active before reset", sr0[0], 1'b1);
    chk("t6 route south", op0[0], SOUTH);
    rdv(0); #1;
    rst = 1'b1; #1;
    chk("t6 va_request", vr0, 4'h0);     chk("t6 sa_request", sr0, 4'h0);
    chk("t6 allocatable", va1, 4'hF);    chk("t6 out_port", op1, 12'h0);
    chk("t6 error", er1, 1'b0);          chk("t6 on_off", oo0, 4'hF);
    @(posedge clk); #1;
    sa_valid_sel_i = 1'b0;
    chk("t6 no credit", cr1, 1'b0);
    rst = 1'b0;
    cyc(); cyc();
    chk("t6 still empty", va0, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
